imem_port_arbiter: RTL

//  Shares the single-port instruction memory between the IFU fetch path and the program loader/debug port.

---
 rtl/core_pkg.sv | 35 +++
 rtl/imem_port_arbiter_if.sv | 46 ++++
 rtl/imem_arb_fsm.sv | 80 ++++++++
 rtl/imem_port_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the instruction memory path.
// Contents: datapath widths, the NOP encoding, the read-slot owner and arbiter
// state encodings, the imem request payload, and a counter-width helper.
package core_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LDR  = 2'd2
    } imem_owner_e;

    typedef enum logic [1:0] {
        S_IFU   = 2'd0,
        S_LDR   = 2'd1,
        S_YIELD = 2'd2
    } imem_arb_state_e;

    // One imem port access
    typedef struct packed {
        logic                   en;
        logic                   we;
        logic [PC_WIDTH-1:0]    addr;
        logic [INSTR_WIDTH-1:0] wdata;
    } imem_req_t;

    // Width of a counter holding 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle around the imem port arbiter.
// Groups the IFU fetch side (ifu_*), the loader/debug side (ldr_*) and the
// imem macro side (mem_*). The slave modport is the arbiter's view; the master
// modport is the view of the surrounding logic (IFU, loader and memory).
interface imem_port_arbiter_if;
    import core_pkg::*;

    logic                   ifu_req;
    logic [PC_WIDTH-1:0]    ifu_addr;
    logic                   ifu_hold;
    logic                   ifu_stall;
    logic [INSTR_WIDTH-1:0] ifu_instr;

    logic                   ldr_vld;
    logic                   ldr_rdy;
    logic                   ldr_we;
    logic [PC_WIDTH-1:0]    ldr_addr;
    logic [INSTR_WIDTH-1:0] ldr_wdata;
    logic                   ldr_rvld;
    logic [INSTR_WIDTH-1:0] ldr_rdata;

    logic                   mem_en;
    logic                   mem_we;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_hold, ifu_stall, ifu_instr,
        input  ldr_vld, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdy, ldr_rvld, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_hold, ifu_stall, ifu_instr,
        output ldr_vld, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdy, ldr_rvld, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_arb_fsm.sv
// Ownership sequencer for the shared imem port.
// Ports: clk, rst (sync, active-high), ldr_vld (loader beat pending),
//        grant_ldr (the port belongs to the loader this cycle).
// In the loader state every valid beat is accepted; a full burst of MAX_BURST
// beats forces YIELD_CYCLES IFU-owned cycles, a partial burst returns at once.
module imem_arb_fsm
    import core_pkg::*;
#(
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned YIELD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ldr_vld,
    output logic grant_ldr
);

    localparam int unsigned BEAT_W  = cnt_width(MAX_BURST);
    localparam int unsigned YIELD_W = cnt_width(YIELD_CYCLES);

    localparam logic [1:0] ST_IFU   = S_IFU;
    localparam logic [1:0] ST_LDR   = S_LDR;
    localparam logic [1:0] ST_YIELD = S_YIELD;

    logic [1:0]         state_q,     state_d;
    logic [BEAT_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic [YIELD_W-1:0] yield_cnt_q, yield_cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IFU;
            beat_cnt_q  <= '0;
            yield_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            yield_cnt_q <= yield_cnt_d;
        end
    end

    // Next state; counters are cleared on every exit so they never wrap
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        yield_cnt_d = yield_cnt_q;
        case (state_q)
            ST_IFU: begin
                if (ldr_vld) state_d = ST_LDR;
            end
            ST_LDR: begin
                if (!ldr_vld) begin
                    state_d    = ST_IFU;
                    beat_cnt_d = '0;
                end else if (beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
                    state_d    = ST_YIELD;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            ST_YIELD: begin
                if (yield_cnt_q == YIELD_W'(YIELD_CYCLES - 1)) begin
                    yield_cnt_d = '0;
                    state_d     = ldr_vld ? ST_LDR : ST_IFU;
                end else begin
                    yield_cnt_d = yield_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IFU;
                beat_cnt_d  = '0;
                yield_cnt_d = '0;
            end
        endcase
    end

    assign grant_ldr = (state_q == ST_LDR);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between IFU fetch and the loader.
// Ports: clk, rst (sync, active-high), bus (imem_port_arbiter_if.slave:
//        ifu_* fetch side, ldr_* loader side, mem_* imem macro side).
// Optional: IMEM_ARB_PERF_EN adds perf_ldr_beats / perf_ifu_stall, saturating
// 32-bit counters of accepted loader beats and ifu_stall cycles.
// The imem port mux is combinational from the current owner; read data is
// routed by owner_q, which tags the 1-cycle-latency read slot.
module imem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned YIELD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_ldr_beats,
    output logic [31:0]         perf_ifu_stall
`endif
);

    logic        grant_ldr;
    logic        ldr_sel;
    logic        ldr_acc;
    imem_req_t   mem_req;
    imem_owner_e owner_q, owner_d;

    imem_arb_fsm #(
        .MAX_BURST    (MAX_BURST),
        .YIELD_CYCLES (YIELD_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .ldr_vld   (bus.ldr_vld),
        .grant_ldr (grant_ldr)
    );

    // Loader never owns the port while reset is asserted, even mid-burst
    assign ldr_sel = grant_ldr & ~rst;
    assign ldr_acc = ldr_sel & bus.ldr_vld;

    // Port mux
    always_comb begin
        mem_req = '0;
        if (ldr_sel) begin
            mem_req.en    = bus.ldr_vld;
            mem_req.we    = bus.ldr_we;
            mem_req.addr  = bus.ldr_addr;
            mem_req.wdata = bus.ldr_wdata;
        end else begin
            mem_req.en    = bus.ifu_req;
            mem_req.addr  = bus.ifu_addr;
        end
    end

    assign bus.mem_en    = mem_req.en;
    assign bus.mem_we    = mem_req.we;
    assign bus.mem_addr  = mem_req.addr;
    assign bus.mem_wdata = mem_req.wdata;
    assign bus.ldr_rdy   = ldr_sel;
    assign bus.ifu_hold  = ldr_sel;

    // Owner of the read slot issued this cycle
    always_comb begin
        owner_d = OWN_NONE;
        if (ldr_sel) begin
            if (bus.ldr_vld && !bus.ldr_we) owner_d = OWN_LDR;
        end else if (bus.ifu_req) begin
            owner_d = OWN_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

    // Read-data routing; data landing during reset is dropped
    assign bus.ifu_stall = rst | (owner_q != OWN_IFU);
    assign bus.ifu_instr = bus.ifu_stall ? INSTR_NOP : bus.mem_rdata;
    assign bus.ldr_rvld  = ~rst & (owner_q == OWN_LDR);
    assign bus.ldr_rdata = bus.mem_rdata;

`ifdef IMEM_ARB_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ldr_beats <= '0;
            perf_ifu_stall <= '0;
        end else begin
            if (ldr_acc && (perf_ldr_beats != 32'hFFFF_FFFF))
                perf_ldr_beats <= perf_ldr_beats + 32'd1;
            if (bus.ifu_stall && (perf_ifu_stall != 32'hFFFF_FFFF))
                perf_ifu_stall <= perf_ifu_stall + 32'd1;
        end
    end
`else
    logic unused_acc;
    assign unused_acc = ldr_acc;
`endif

endmodule
